mem_access_unit: RTL and testbench

Initiator side of the core's single-port data memory interface. Accepts byte/half/word/doubleword load and store requests from the pipeline on a byte address. Converts each request into one valid/ready/rvalid transaction with aligned 64-bit data and byte write mask. Returns load data shifted, truncated and sign- or zero-extended. Sits between the execute/memory stage and the 64-bit memory block.

---
 rtl/mem_access_unit.sv | 124 ++++++++++++
 tb/tb_mem_access_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for the 64-bit single-port data memory: turns byte-addressed
// pipeline requests into one valid/ready/rvalid transaction and extends returned load data.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [63:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [63:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [63:0]           resp_rdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]           mem_wdata,
  output logic [7:0]            mem_wmask,
  input  logic                  mem_rvalid,
  input  logic [63:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state;
  logic [2:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[63:ADDR_WIDTH+3];
  assign req_ready        = rst && (state == IDLE);

  function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] sz);
    case (sz)
      2'd1:    misaligned = lo[0];
      2'd2:    misaligned = |lo[1:0];
      2'd3:    misaligned = |lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] store_mask(input logic [2:0] lo, input logic [1:0] sz);
    case (sz)
      2'd0:    store_mask = 8'h01 << lo;
      2'd1:    store_mask = 8'h03 << lo;
      2'd2:    store_mask = 8'h0F << lo;
      default: store_mask = 8'hFF;
    endcase
  endfunction

  // Dword loads pass straight through, so the unsigned flag is irrelevant for them.
  function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] lo,
                                              input logic [1:0] sz, input logic zx);
    logic [63:0] s;
    s = word >> {lo, 3'b000};
    case (sz)
      2'd0:    load_extend = zx ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      2'd1:    load_extend = zx ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'd2:    load_extend = zx ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: load_extend = s;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misaligned(req_addr[2:0], req_size)) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              // mem_* are captured once here and held until the next accepted request.
              mem_valid    <= 1'b1;
              mem_wen      <= req_wen;
              mem_addr     <= req_addr[ADDR_WIDTH+2:3];
              mem_wdata    <= req_wdata << {req_addr[2:0], 3'b000};
              mem_wmask    <= store_mask(req_addr[2:0], req_size);
              lat_off      <= req_addr[2:0];
              lat_size     <= req_size;
              lat_unsigned <= req_unsigned;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= mem_wen ? 64'd0
                                  : load_extend(mem_rdata, lat_off, lat_size, lat_unsigned);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level memory reference model, per-cycle output compare,
// bench-side memory responder, directed literal cases and a randomized request stream.
module tb_mem_access_unit;
  localparam int AW = 8;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0;
  logic [63:0]   req_addr = '0, req_wdata = '0;
  logic [1:0]    req_size = '0;
  logic          req_ready, resp_valid, resp_err;
  logic [63:0]   resp_rdata;
  logic          mem_valid, mem_wen;
  logic          mem_ready = 1'b1, mem_rvalid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata, mem_rdata = '0;
  logic [7:0]    mem_wmask;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory plus the single outstanding transaction.
  logic [7:0]    rb [0:NW*8-1];
  logic [63:0]   phys [0:NW-1];
  bit            cur_act = 0, cur_al = 0, cur_wen = 0, acc_done = 0, e_err = 0;
  int            hs = 0, due = -1, cyc = 0;
  logic [AW-1:0] e_addr = '0;
  logic [7:0]    e_mask = '0;
  logic [63:0]   e_wdata = '0, e_rdata = '0, lane = '0;
  logic [63:0]   last_rdata = '0, dut_rdata = '0, mdl_rdata = '0, cap_wdata = '0;
  bit            last_err = 0, dut_err = 0, started = 0, prev_rst_low = 0;
  bit            exp_rv = 0, exp_mv = 0, exp_rdy = 0;
  int            last_lat = 0, acc_cnt = 0, mv_cnt = 0;
  logic [AW-1:0] cap_addr = '0;
  logic [7:0]    cap_mask = '0;
  int            force_stall = 0, p_stall = 0;

  function automatic void model_accept();
    int a, n, o;
    logic [63:0] v;
    a = int'(req_addr[AW+2:0]);
    n = 1 << req_size;
    o = a % 8;
    cur_act = 1; hs = cyc; acc_done = 0; due = -1; cur_wen = req_wen;
    e_addr = req_addr[AW+2:3]; e_mask = '0; e_wdata = '0; e_rdata = '0;
    if (a % n != 0) begin
      cur_al = 0; e_err = 1; due = cyc + 1;
    end else begin
      cur_al = 1; e_err = 0; v = '0;
      for (int j = 0; j < n; j++) begin
        if (req_wen) begin
          rb[a+j] = req_wdata[8*j +: 8];
          e_mask[o+j] = 1'b1;
          e_wdata[8*(o+j) +: 8] = req_wdata[8*j +: 8];
        end else begin
          v[8*j +: 8] = rb[a+j];
        end
      end
      if (!req_wen) begin
        if (n < 8 && !req_unsigned && v[8*n-1])
          for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
        e_rdata = v;
      end
    end
  endfunction

  always begin
    @(negedge clk);
    exp_rv = cur_act && (cyc == due);
    exp_mv = cur_act && cur_al && (cyc > hs) && !acc_done;
    exp_rdy = rst && !(cur_act && cur_al && !exp_rv);
    if (started) begin
      chk("req_ready", req_ready, exp_rdy);
      chk("mem_valid", mem_valid, exp_mv);
      if (mem_valid) mv_cnt++;
      if (prev_rst_low) begin
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
      end
      if (cur_act && cur_al && cyc > hs && !exp_rv) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wen", mem_wen, cur_wen);
        if (cur_wen) begin
          for (int j = 0; j < 8; j++) lane[8*j +: 8] = {8{e_mask[j]}};
          chk("mem_wmask", mem_wmask, e_mask);
          chk("mem_wdata", mem_wdata & lane, e_wdata);
        end
      end
      chk("resp_valid", resp_valid, exp_rv);
      if (exp_rv) begin
        chk("resp_err", resp_err, e_err);
        chk("resp_rdata", resp_rdata, e_rdata);
        last_err = e_err; last_rdata = e_rdata; last_lat = cyc - hs;
        dut_rdata = resp_rdata; dut_err = resp_err; mdl_rdata = e_rdata;
        cur_act = 0;
      end else begin
        chk("resp_err_hold", resp_err, last_err);
        chk("resp_rdata_hold", resp_rdata, last_rdata);
      end
      if (cur_act && cyc - hs > 200) begin
        n_chk++; n_fail++;
        $display("FAIL resp_timeout: no response after %0d cycles, required one", cyc - hs);
        cur_act = 0;
      end
    end
    if (!rst) begin
      started = 1; cur_act = 0; last_err = 0; last_rdata = 0;
    end else if (started) begin
      if (cur_act && cur_al && !acc_done && mem_valid && mem_ready) begin
        acc_done = 1; due = cyc + (cur_wen ? 3 : 2); acc_cnt++;
        cap_addr = mem_addr; cap_mask = mem_wmask; cap_wdata = mem_wdata;
      end
      if (req_valid && exp_rdy) model_accept();
    end
    prev_rst_low = !rst;
    cyc++;
  end

  // Memory responder: load data one cycle after accept; stores busy one cycle, then rvalid.
  int            mst = 0, nxt = 0;
  logic [AW-1:0] la = '0;
  bit            spur = 0;

  function automatic logic pick_ready();
    return (force_stall > 0) ? 1'b0 : ($urandom_range(0, 99) >= p_stall);
  endfunction

  always begin
    @(negedge clk);
    nxt = 0;
    case (mst)
      0: if (mem_valid && mem_ready) begin la = mem_addr; nxt = mem_wen ? 2 : 1; end
      2: begin
        for (int j = 0; j < 8; j++)
          if (mem_wmask[j]) phys[mem_addr][8*j +: 8] = mem_wdata[8*j +: 8];
        nxt = 3;
      end
      default: nxt = 0;
    endcase
    spur = (mst == 0) && mem_valid && !mem_ready && ($urandom_range(0, 2) == 0);
    if (mem_valid && force_stall > 0) force_stall--;
    @(posedge clk);
    #1;
    mst = nxt;
    case (nxt)
      1: begin mem_rvalid = 1'b1; mem_rdata = phys[la]; mem_ready = pick_ready(); end
      2: begin mem_rvalid = 1'b0; mem_ready = 1'b0; end
      3: begin mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom}; mem_ready = pick_ready(); end
      default: begin mem_rvalid = spur; mem_rdata = {$urandom, $urandom}; mem_ready = pick_ready(); end
    endcase
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [63:0] a, input logic [1:0] sz,
                      input logic u, input logic [63:0] d, input bit keep);
    bit ok;
    req_wen = w; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = d;
    req_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL req_handshake: req_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (!cur_act) begin ok = 1; break; end
      idle(1);
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done: transaction still open, required completion");
    end
  endtask

  task automatic set_word(input int w, input logic [63:0] v);
    phys[w] = v;
    for (int j = 0; j < 8; j++) rb[w*8+j] = v[8*j +: 8];
  endtask

  logic [63:0] ld_addr [5] = '{64'h0F, 64'h0F, 64'h0A, 64'h0C, 64'h08};
  logic [1:0]  ld_size [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
  logic        ld_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [63:0] ld_exp  [5] = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'h4433,
                               64'hFFFFFFFF88776655, 64'h8877665544332211};

  initial begin
    int mv0, a0, gap, sz, n, ad;
    logic [7:0] sb;
    logic [63:0] d;
    for (int w = 0; w < NW; w++) set_word(w, {$urandom, $urandom});
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    p_stall = 0;
    set_word(1, 64'h8877665544332211);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, ld_addr[i], ld_size[i], ld_uns[i], 64'd0, 0);
      wait_done();
      chk("load_lit_dut", dut_rdata, ld_exp[i]);
      chk("load_lit_model", mdl_rdata, ld_exp[i]);
      chk("load_latency", last_lat, 3);
    end

    set_word(2, 64'h0123456789ABCDEF);
    send(1'b1, 64'h12, 2'd1, 1'b0, 64'h123456789ABCBEEF, 0);
    wait_done();
    chk("sh_mem_addr", cap_addr, 2);
    chk("sh_mem_wmask", cap_mask, 8'h0C);
    chk("sh_mem_wdata", cap_wdata[31:16], 16'hBEEF);
    chk("sh_latency", last_lat, 4);
    send(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 0);
    wait_done();
    chk("sh_readback", dut_rdata, 64'h01234567BEEFCDEF);

    mv0 = mv_cnt;
    send(1'b0, 64'h06, 2'd2, 1'b0, 64'd0, 0);
    wait_done();
    chk("mis_lw_err", dut_err, 1);
    chk("mis_lw_rdata", dut_rdata, 0);
    chk("mis_lw_latency", last_lat, 1);
    send(1'b1, 64'h04, 2'd3, 1'b0, 64'hDEADBEEFCAFEF00D, 0);
    wait_done();
    chk("mis_sd_err", dut_err, 1);
    chk("mis_sd_latency", last_lat, 1);
    chk("mis_no_mem_valid", mv_cnt - mv0, 0);
    send(1'b0, 64'h00, 2'd3, 1'b0, 64'd0, 0);
    wait_done();

    force_stall = 3;
    send(1'b0, 64'h08, 2'd3, 1'b0, 64'd0, 0);
    wait_done();
    chk("bp_latency", last_lat, 6);
    chk("bp_rdata", dut_rdata, 64'h8877665544332211);

    mv0 = mv_cnt;
    sb = '0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        sb = 8'($urandom);
        send(1'b1, 64'h20, 2'd0, 1'b0, {56'($urandom), sb}, 1);
      end else begin
        send(1'b0, 64'h20, 2'd0, 1'b1, 64'd0, i < 7);
      end
    end
    wait_done();
    chk("b2b_last_lbu", dut_rdata, {56'd0, sb});
    chk("b2b_mem_valid_cycles", mv_cnt - mv0, 8);

    a0 = acc_cnt;
    d = 64'hA5A5_1234_5678_9ABC;
    send(1'b1, 64'h28, 2'd3, 1'b0, d, 0);
    for (int k = 0; k < 50 && acc_cnt == a0; k++) idle(1);
    chk("rst_store_accepted", acc_cnt - a0, 1);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", req_ready, 1);
    chk("rst_release_mem_valid", mem_valid, 0);
    chk("rst_release_resp_valid", resp_valid, 0);
    idle(1);
    send(1'b0, 64'h28, 2'd3, 1'b0, 64'd0, 0);
    wait_done();
    chk("rst_next_ld", dut_rdata, d);

    p_stall = 25;
    for (int i = 0; i < 300; i++) begin
      sz = $urandom_range(0, 3);
      n = 1 << sz;
      ad = $urandom_range(0, 255);
      if ($urandom_range(0, 9) < 7) ad = ad & ~(n - 1);
      gap = $urandom_range(0, 2);
      send(1'($urandom), {$urandom, 21'($urandom), 11'(ad)}, 2'(sz), 1'($urandom),
           {$urandom, $urandom}, (gap == 0) && (i < 299));
      if (gap > 0) idle(gap);
    end
    wait_done();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
